// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, loader and SRAM signal bundle for the instruction memory arbiter
interface imem_arbiter_if #(
    parameter int ADDR_W = 11
);
    // fetch stage
    logic              f_req;
    logic [63:0]       f_addr;
    logic              f_flush;
    logic              f_gnt;
    logic              f_rvalid;
    logic [31:0]       f_rdata;
    logic              f_exc_en;
    logic [3:0]        f_exc_code;
    logic [63:0]       f_exc_val;
    // program loader
    logic              l_req;
    logic              l_we;
    logic [63:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [31:0]       l_rdata;
    logic              l_err;
    // synchronous instruction SRAM
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // environment side: requesters and the SRAM
    modport master (
        output f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, f_exc_en, f_exc_code, f_exc_val,
        input  l_gnt, l_rvalid, l_rdata, l_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    // arbiter side
    modport slave (
        input  f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, f_exc_en, f_exc_code, f_exc_val,
        output l_gnt, l_rvalid, l_rdata, l_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction SRAM arbiter between fetch and loader with fetch fault generation
module imem_arbiter #(
    parameter int MEM_WORDS  = 2048,
    parameter int ADDR_W     = 11,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OWN_FETCH  = 2'd0,
        OWN_LOADER = 2'd1,
        OWN_FAULT  = 2'd2,
        OWN_ERR    = 2'd3
    } owner_e;

    localparam logic [63:0] BYTE_LIMIT = 64'(4 * MEM_WORDS);
    localparam int          CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             pend_q, pend_d;
    owner_e           own_q, own_d;
    logic             l_wr_q, l_wr_d;
    logic [3:0]       exc_code_q, exc_code_d;
    logic [63:0]      exc_val_q, exc_val_d;
    logic [31:0]      f_rdata_q, f_rdata_d;
    logic [31:0]      l_rdata_q, l_rdata_d;

    logic f_mis, f_ok, l_ok, f_gnt, l_gnt;

    // Address legality and grant selection; grants are held off while in reset
    always_comb begin
        f_mis = (bus.f_addr[1:0] != 2'b00);
        f_ok  = !f_mis && (bus.f_addr < BYTE_LIMIT);
        l_ok  = (bus.l_addr[1:0] == 2'b00) && (bus.l_addr < BYTE_LIMIT);
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (rst_n) begin
            if (bus.f_req && !bus.f_flush && bus.l_req) begin
                f_gnt = (starve_q == CNT_MAX);
                l_gnt = !f_gnt;
            end else begin
                f_gnt = bus.f_req && !bus.f_flush;
                l_gnt = bus.l_req;
            end
        end
    end

    // SRAM drive in the grant cycle; illegal accesses never touch the array
    always_comb begin
        bus.f_gnt     = f_gnt;
        bus.l_gnt     = l_gnt;
        bus.mem_en    = (f_gnt && f_ok) || (l_gnt && l_ok);
        bus.mem_we    = l_gnt && l_ok && bus.l_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (l_gnt) begin
            bus.mem_addr  = bus.l_addr[ADDR_W+1:2];
            bus.mem_wdata = bus.l_wdata;
        end else if (f_gnt) begin
            bus.mem_addr  = bus.f_addr[ADDR_W+1:2];
        end
    end

    // Next state: starvation counter, response owner tag and captured fault info
    always_comb begin
        starve_d   = starve_q;
        pend_d     = f_gnt || l_gnt;
        own_d      = own_q;
        l_wr_d     = l_wr_q;
        exc_code_d = exc_code_q;
        exc_val_d  = exc_val_q;
        if (!bus.f_req || f_gnt) begin
            starve_d = '0;
        end else if (l_gnt && starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end
        if (f_gnt) begin
            own_d = f_ok ? OWN_FETCH : OWN_FAULT;
            if (!f_ok) begin
                exc_code_d = f_mis ? 4'd0 : 4'd1;
                exc_val_d  = bus.f_addr;
            end
        end else if (l_gnt) begin
            own_d  = l_ok ? OWN_LOADER : OWN_ERR;
            l_wr_d = bus.l_we;
        end
    end

    // Response routing; data outputs hold their last delivered value when idle
    always_comb begin
        bus.f_rvalid   = pend_q && (own_q == OWN_FETCH || own_q == OWN_FAULT) && !bus.f_flush;
        bus.f_exc_en   = bus.f_rvalid && (own_q == OWN_FAULT);
        bus.f_exc_code = exc_code_q;
        bus.f_exc_val  = exc_val_q;
        bus.f_rdata    = f_rdata_q;
        if (bus.f_rvalid) begin
            bus.f_rdata = (own_q == OWN_FAULT) ? 32'h0000_0013 : bus.mem_rdata;
        end
        bus.l_rvalid = pend_q && (own_q == OWN_LOADER || own_q == OWN_ERR);
        bus.l_err    = bus.l_rvalid && (own_q == OWN_ERR);
        bus.l_rdata  = l_rdata_q;
        if (bus.l_rvalid) begin
            bus.l_rdata = (own_q == OWN_LOADER && !l_wr_q) ? bus.mem_rdata : 32'h0;
        end
        f_rdata_d = bus.f_rdata;
        l_rdata_d = bus.l_rdata;
    end

    // State registers; reset drops any pending response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q   <= '0;
            pend_q     <= 1'b0;
            own_q      <= OWN_FETCH;
            l_wr_q     <= 1'b0;
            exc_code_q <= '0;
            exc_val_q  <= '0;
            f_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            starve_q   <= starve_d;
            pend_q     <= pend_d;
            own_q      <= own_d;
            l_wr_q     <= l_wr_d;
            exc_code_q <= exc_code_d;
            exc_val_q  <= exc_val_d;
            f_rdata_q  <= f_rdata_d;
            l_rdata_q  <= l_rdata_d;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - self-checking bench for imem_arbiter
module tb_imem_arbiter;
    localparam int MEM_WORDS  = 2048;
    localparam int ADDR_W     = 11;
    localparam int STARVE_MAX = 4;
    localparam int LOW_WORDS  = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    imem_arbiter #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // SRAM model
    logic [31:0] sram [MEM_WORDS];
    logic [31:0] rd_q = '0;
    assign bus.mem_rdata = rd_q;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else            rd_q <= sram[bus.mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] ref_mem [MEM_WORDS];
    int          m_starve = 0;
    bit          exp_f = 0, exp_f_fault = 0, exp_l = 0, exp_l_err = 0;
    logic [31:0] exp_f_data = '0, exp_l_data = '0;
    logic [3:0]  exp_code = '0;
    logic [63:0] exp_val = '0;
    bit          last_fg, last_lg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [63:0] a);
        return (a % 4 == 0) && (a < 64'(4 * MEM_WORDS));
    endfunction

    function automatic logic [63:0] rand_addr();
        int r = $urandom_range(0, 9);
        logic [63:0] a;
        if (r < 7)       a = 64'($urandom_range(0, LOW_WORDS - 1)) * 4;
        else if (r == 7) a = 64'($urandom_range(0, LOW_WORDS - 1)) * 4 + 64'($urandom_range(1, 3));
        else if (r == 8) a = 64'(4 * MEM_WORDS) + 64'($urandom_range(0, 255)) * 4;
        else             a = {$urandom, $urandom} | 64'h0000_0001_0000_0000;
        return a;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_f_gnt"}, bus.f_gnt, 0);
        chk({tag, "_l_gnt"}, bus.l_gnt, 0);
        chk({tag, "_f_rvalid"}, bus.f_rvalid, 0);
        chk({tag, "_l_rvalid"}, bus.l_rvalid, 0);
        chk({tag, "_f_rdata"}, bus.f_rdata, 0);
        chk({tag, "_l_rdata"}, bus.l_rdata, 0);
        chk({tag, "_f_exc"}, {bus.f_exc_en, bus.f_exc_code, bus.l_err}, 0);
        chk({tag, "_f_exc_val"}, bus.f_exc_val, 0);
        chk({tag, "_mem"}, {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    endtask

    // One clock: check responses and grants at the falling edge, then update the model
    task automatic cycle();
        bit fwant, fg, lg, fok, lok;
        int fi, li;
        @(negedge clk);
        if (exp_f && !bus.f_flush) begin
            chk("f_rvalid", bus.f_rvalid, 1);
            chk("f_rdata", bus.f_rdata, exp_f_data);
            chk("f_exc_en", bus.f_exc_en, exp_f_fault);
            if (exp_f_fault) begin
                chk("f_exc_code", bus.f_exc_code, exp_code);
                chk("f_exc_val", bus.f_exc_val, exp_val);
            end
        end else begin
            chk("f_rvalid_idle", bus.f_rvalid, 0);
        end
        if (exp_l) begin
            chk("l_rvalid", bus.l_rvalid, 1);
            chk("l_rdata", bus.l_rdata, exp_l_data);
            chk("l_err", bus.l_err, exp_l_err);
        end else begin
            chk("l_rvalid_idle", bus.l_rvalid, 0);
        end
        chk("starve_cnt", dut.starve_q, m_starve);

        fwant = bus.f_req && !bus.f_flush;
        if (fwant && bus.l_req) begin
            fg = (m_starve == STARVE_MAX);
            lg = !fg;
        end else begin
            fg = fwant;
            lg = bus.l_req;
        end
        fok = legal(bus.f_addr);
        lok = legal(bus.l_addr);
        chk("f_gnt", bus.f_gnt, fg);
        chk("l_gnt", bus.l_gnt, lg);
        chk("mem_en", bus.mem_en, (fg && fok) || (lg && lok));
        if (fg && fok) begin
            chk("mem_addr_f", bus.mem_addr, bus.f_addr / 4);
            chk("mem_we_f", bus.mem_we, 0);
        end
        if (lg && lok) begin
            chk("mem_addr_l", bus.mem_addr, bus.l_addr / 4);
            chk("mem_we_l", bus.mem_we, bus.l_we);
            if (bus.l_we) chk("mem_wdata", bus.mem_wdata, bus.l_wdata);
        end

        if (!bus.f_req || fg) m_starve = 0;
        else if (lg && m_starve < STARVE_MAX) m_starve++;

        exp_f = fg;
        exp_l = lg;
        if (fg) begin
            exp_f_fault = !fok;
            exp_code    = (bus.f_addr % 4 != 0) ? 4'd0 : 4'd1;
            exp_val     = bus.f_addr;
            fi          = fok ? int'(bus.f_addr / 4) : 0;
            exp_f_data  = fok ? ref_mem[fi] : 32'h0000_0013;
        end
        if (lg) begin
            exp_l_err  = !lok;
            li         = lok ? int'(bus.l_addr / 4) : 0;
            exp_l_data = (lok && !bus.l_we) ? ref_mem[li] : 32'h0;
            if (lok && bus.l_we) ref_mem[li] = bus.l_wdata;
        end
        last_fg = fg;
        last_lg = lg;
        @(posedge clk);
        #1;
    endtask

    task automatic drop_granted();
        if (last_fg) bus.f_req = 1'b0;
        if (last_lg) bus.l_req = 1'b0;
    endtask

    initial begin
        int fcount;
        rst_n       = 1'b0;
        bus.f_req   = 0; bus.f_addr = '0; bus.f_flush = 0;
        bus.l_req   = 0; bus.l_we   = 0;  bus.l_addr  = '0; bus.l_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // preload the low region through the loader
        for (int i = 0; i < LOW_WORDS; i++) begin
            bus.l_req = 1; bus.l_we = 1; bus.l_addr = 64'(i) * 4; bus.l_wdata = $urandom;
            cycle();
            drop_granted();
        end
        cycle();

        // fetch 0x0 then 0x4 back to back
        bus.f_req = 1; bus.f_addr = 64'h0;
        cycle();
        bus.f_addr = 64'h4;
        cycle();
        bus.f_req = 0;
        cycle();
        cycle();

        // loader writes DEADBEEF to 0x10, fetch reads it back
        bus.l_req = 1; bus.l_we = 1; bus.l_addr = 64'h10; bus.l_wdata = 32'hDEAD_BEEF;
        cycle();
        bus.l_req = 0;
        bus.f_req = 1; bus.f_addr = 64'h10;
        cycle();
        bus.f_req = 0;
        cycle();
        chk("deadbeef_fetch", bus.f_rdata, 32'hDEAD_BEEF);

        // fetch faults and loader errors
        bus.f_req = 1; bus.f_addr = 64'h2002;
        cycle();
        bus.f_addr = 64'h2000;
        cycle();
        bus.f_addr = 64'h1_0000_0000;
        cycle();
        bus.f_req = 0;
        bus.l_req = 1; bus.l_we = 0; bus.l_addr = 64'h2000;
        cycle();
        bus.l_we = 1; bus.l_addr = 64'h3; bus.l_wdata = 32'h1234_5678;
        cycle();
        bus.l_req = 0;
        cycle();

        // both requesting continuously: L,L,L,L,F repeating
        fcount = 0;
        bus.f_req = 1; bus.f_addr = 64'h20;
        bus.l_req = 1; bus.l_we = 0; bus.l_addr = 64'h24;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (last_fg) fcount++;
        end
        chk("starve_fetch_grants", fcount, 3);
        bus.f_req = 0; bus.l_req = 0;
        cycle();

        // flush in the response cycle drops the response
        bus.f_req = 1; bus.f_addr = 64'h8;
        cycle();
        bus.f_req = 0; bus.f_flush = 1;
        cycle();
        // flush with request held blocks the grant for that cycle
        bus.f_req = 1; bus.f_addr = 64'hC;
        cycle();
        bus.f_flush = 0;
        cycle();
        bus.f_req = 0;
        cycle();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (!bus.f_req && $urandom_range(0, 2) == 0) begin
                bus.f_req = 1; bus.f_addr = rand_addr();
            end
            if (!bus.l_req && $urandom_range(0, 2) == 0) begin
                bus.l_req = 1; bus.l_we = 1'($urandom_range(0, 1));
                bus.l_addr = rand_addr(); bus.l_wdata = $urandom;
            end
            bus.f_flush = ($urandom_range(0, 9) == 0);
            cycle();
            drop_granted();
        end
        bus.f_req = 0; bus.l_req = 0; bus.f_flush = 0;
        cycle();

        // reset in the cycle after a grant
        bus.l_req = 1; bus.l_we = 0; bus.l_addr = 64'h8;
        cycle();
        bus.l_req = 0;
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        exp_f = 0; exp_l = 0; m_starve = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the single-port instruction memory between the core's fetch stage and the program loader (debug/boot write port). Fetch addresses are checked for alignment and range before any memory access; faulting fetches return a NOP with exception information instead of touching the array. Sits between the fetch stage / loader and the synchronous instruction SRAM. It owns grant, response routing, fault generation and starvation control.

## Interface
- MEM_WORDS, 2048: array depth in 32-bit words; the legal byte range is 0 .. 4*MEM_WORDS-1.
- ADDR_W, 11: word-address width, clog2(MEM_WORDS).
- STARVE_MAX, 4: consecutive lost contests after which fetch wins over the loader.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch request; held until f_gnt.
- f_addr  in  64  fetch byte address (PC).
- f_flush  in  1  redirect; cancels in-flight fetch response, blocks f_gnt this cycle.
- f_gnt  out  1  fetch accepted this cycle (combinational).
- f_rvalid  out  1  fetch response valid (registered).
- f_rdata  out  32  instruction; 0x00000013 on fault.
- f_exc_en  out  1  response is a fault.
- f_exc_code  out  4  0 = instruction misaligned, 1 = instruction access fault.
- f_exc_val  out  64  faulting address (mtval).
- l_req  in  1  loader request; held until l_gnt.
- l_we  in  1  1 = write, 0 = read.
- l_addr  in  64  loader byte address.
- l_wdata  in  32  write data.
- l_gnt  out  1  loader accepted this cycle (combinational).
- l_rvalid  out  1  loader response (read data, or write ack).
- l_rdata  out  32  read data; 0 on error or write.
- l_err  out  1  out-of-range or misaligned loader access; no memory effect.
- mem_en, mem_we  out  1  SRAM enable and write strobe.
- mem_addr  out  ADDR_W  SRAM word address, addr[ADDR_W+1:2].
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after a read enable.

## Operation
- Legality: an address is legal iff addr[1:0]==0 and addr < 4*MEM_WORDS, compared on the full 64 bits. A high bit set above the array range is illegal; the address does not alias.
- Fetch fault priority: misaligned (code 0) is checked before out-of-range (code 1).
- Arbitration when both requests are present: the loader wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
- starve_cnt: increments, saturating, when f_req is high and the loader is granted. It clears when fetch is granted or f_req is low.
- Single request: granted immediately unless f_flush blocks fetch.
- Exactly one grant per cycle, or none.
- Memory access: a legal granted request drives mem_en=1 in the grant cycle.
  - mem_we=l_we for the loader.
  - mem_we=0 for fetch.
- Illegal granted request: still granted and still answered, but mem_en stays 0.
- Response routing: a 2-bit registered owner tag (fetch / loader / fault-fetch / err-loader) selects the destination on the next cycle.
- The loader always gets exactly one response per grant.
- Fetch response suppression: the fetch response is dropped if f_flush is high in the grant cycle or in the response cycle.
- Fault response: f_rvalid=1, f_exc_en=1, f_rdata=0x00000013, f_exc_code as above, f_exc_val = the granted f_addr.
  - The fault is one-shot per grant. A new fault needs a new grant.

## Timing
- Reset: all outputs are 0, starve_cnt=0, owner tag is idle.
- Reset mid-operation discards any pending response. No rvalid appears after rst_n deasserts.
- Latency: grant in cycle N produces the response in cycle N+1. This holds for memory, fault and error responses alike.
- Throughput: one access per cycle. Back-to-back grants are allowed, and a response and a new grant coexist in the same cycle.
- The requester must hold req, addr, we and wdata stable until gnt. After gnt it may change them in the same edge.
- f_rdata, f_exc_* and l_rdata hold their last value when rvalid=0. Their content is don't-care in that state but must not be X.

## Test plan
- Fetch only, f_addr=0x0 and then 0x4 back to back: f_gnt each cycle; f_rvalid on cycles N+1 and N+2 with f_rdata = mem[0] and mem[1]; f_exc_en=0.
- Loader writes 0xDEADBEEF to 0x10, then fetch reads 0x10: l_rvalid ack with l_err=0; the fetch then returns 0xDEADBEEF.
- Fetch 0x2002 (MEM_WORDS=2048): f_exc_en=1, code 0, f_exc_val=0x2002, f_rdata=0x13, no mem_en. Fetch 0x2000: code 1, f_exc_val=0x2000, no mem_en. Fetch 0x1_0000_0000: code 1.
- Loader and fetch both continuously requesting, STARVE_MAX=4: the grant pattern is L,L,L,L,F repeating; starve_cnt returns to 0 after each F.
- f_flush asserted in the cycle after a fetch grant: f_rvalid stays 0. Also f_flush with f_req held: f_gnt=0 that cycle and the grant follows next cycle.
- rst_n pulled low in the cycle after a grant: all outputs go to 0 asynchronously, and no response appears after release.
